// File: rtl/spike_aer_tx.sv
// -----------------------------------------------------------------------------
// spike_aer_tx
//
// Two-neuron Address-Event Representation transmitter. Rising edges on the
// two spike inputs become events (source address + optional timestamp). The
// events are queued in a small FIFO and sent one at a time over a 4-phase
// req/ack handshake.
//
// Parameters
//   TS_WIDTH    timestamp width in bits
//   FIFO_DEPTH  event FIFO entries (power of two, >= 2)
//
// Ports
//   clk         rising-edge clock, the only clock
//   rst         synchronous, active-high reset
//   spike_in    neuron spike levels; bit0 -> address 0, bit1 -> address 1
//   aer_req     4-phase request (registered)
//   aer_ack     4-phase acknowledge from the receiver
//   aer_addr    source address of the presented event (registered)
//   aer_ts      timestamp of the presented event (registered)
//   fifo_level  current FIFO occupancy
//   overflow    sticky: at least one event was dropped since reset
//
// Configuration
//   AER_TX_TIMESTAMP_EN  when defined, a free-running timestamp counter and
//                        per-entry timestamp storage are built and aer_ts
//                        carries the event timestamp. When undefined, both are
//                        omitted and aer_ts is tied to zero.
// -----------------------------------------------------------------------------
module spike_aer_tx #(
  parameter int TS_WIDTH   = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    spike_in,
  output logic                          aer_req,
  input  logic                          aer_ack,
  output logic                          aer_addr,
  output logic [TS_WIDTH-1:0]           aer_ts,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACKLOW
  } state_e;

  // ---------------------------------------------------------------------------
  // Spike edge detection
  // ---------------------------------------------------------------------------
  // hold_q masks a bit that was already high when reset was sampled, so a
  // level held through reset release is not mistaken for a new spike. The
  // mask bit clears as soon as the input is seen low.
  logic [1:0] spike_q;
  logic [1:0] hold_q;
  logic [1:0] spike_evt;

  assign spike_evt = spike_in & ~spike_q & ~hold_q;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      spike_q <= '0;
      hold_q  <= spike_in;
    end else begin
      spike_q <= spike_in;
      hold_q  <= hold_q & spike_in;
    end
  end

`ifdef AER_TX_TIMESTAMP_EN
  // ---------------------------------------------------------------------------
  // Free-running timestamp counter, wraps naturally at 2^TS_WIDTH
  // ---------------------------------------------------------------------------
  logic [TS_WIDTH-1:0] ts_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + TS_WIDTH'(1);
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Write source selection
  // ---------------------------------------------------------------------------
  // The FIFO takes one write per cycle. When both neurons fire together,
  // address 0 is written now and address 1 is parked in the pending register
  // (with the same timestamp) and written on the following edge. A new edge
  // cannot coincide with a pending write because each input needs at least
  // two cycles between rising edges.
  logic                pend_q, pend_d;
  logic                wr_en;
  logic                wr_addr;
`ifdef AER_TX_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] pend_ts_q, pend_ts_d;
  logic [TS_WIDTH-1:0] wr_ts;
`endif

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_en     = 1'b0;
    wr_addr   = 1'b0;
    pend_d    = 1'b0;
`ifdef AER_TX_TIMESTAMP_EN
    wr_ts     = ts_cnt_q;
    pend_ts_d = pend_ts_q;
`endif
    if (pend_q) begin
      wr_en   = 1'b1;
      wr_addr = 1'b1;
`ifdef AER_TX_TIMESTAMP_EN
      wr_ts   = pend_ts_q;
`endif
    end else if (spike_evt[0]) begin
      wr_en   = 1'b1;
      wr_addr = 1'b0;
      if (spike_evt[1]) begin
        pend_d    = 1'b1;
`ifdef AER_TX_TIMESTAMP_EN
        pend_ts_d = ts_cnt_q;
`endif
      end
    end else if (spike_evt[1]) begin
      wr_en   = 1'b1;
      wr_addr = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------------
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]       level_q, level_d;
  logic                mem_addr_q [FIFO_DEPTH];
`ifdef AER_TX_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] mem_ts_q   [FIFO_DEPTH];
`endif
  logic                overflow_q;
  logic                pop;
  logic                push;
  logic                drop;

  state_e              state_q, state_d;

  // The head has already been copied to the output registers when the pop
  // happens, so a full FIFO may overwrite the head slot in the same cycle.
  assign pop  = (state_q == ST_REQ) && aer_ack;
  assign push = wr_en && ((level_q != LW'(FIFO_DEPTH)) || pop);
  assign drop = wr_en && !push;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: storage entries carry no reset; the pointers and level define what
  // is valid, so clearing those flushes the FIFO.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= wr_addr;
`ifdef AER_TX_TIMESTAMP_EN
      mem_ts_q[wr_ptr_q]   <= wr_ts;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      pend_q     <= 1'b0;
`ifdef AER_TX_TIMESTAMP_EN
      pend_ts_q  <= '0;
`endif
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q <= level_d;
      if (drop) overflow_q <= 1'b1;
      pend_q <= pend_d;
`ifdef AER_TX_TIMESTAMP_EN
      pend_ts_q <= pend_ts_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // 4-phase handshake FSM
  // ---------------------------------------------------------------------------
  logic                req_q, req_d;
  logic                addr_q, addr_d;
`ifdef AER_TX_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_q, ts_d;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
`ifdef AER_TX_TIMESTAMP_EN
    ts_d    = ts_q;
`endif
    case (state_q)
      // aer_ack is deliberately ignored here.
      ST_IDLE: begin
        if (level_q != '0) begin
          addr_d  = mem_addr_q[rd_ptr_q];
`ifdef AER_TX_TIMESTAMP_EN
          ts_d    = mem_ts_q[rd_ptr_q];
`endif
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      // Address and timestamp hold steady while the request is up.
      ST_REQ: begin
        if (aer_ack) begin
          req_d   = 1'b0;
          state_d = ST_ACKLOW;
        end
      end
      ST_ACKLOW: begin
        if (!aer_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // Reset aborts any transfer in flight: the request drops at the reset edge
  // whatever the receiver is doing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      addr_q  <= 1'b0;
`ifdef AER_TX_TIMESTAMP_EN
      ts_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
`ifdef AER_TX_TIMESTAMP_EN
      ts_q    <= ts_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign aer_req    = req_q;
  assign aer_addr   = addr_q;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
`ifdef AER_TX_TIMESTAMP_EN
  assign aer_ts     = ts_q;
`else
  assign aer_ts     = '0;
`endif

endmodule

// File: doc/spike_aer_tx.md
SPIKE_AER_TX -- requirements
Module: spike_aer_tx

Interface
REQ-001 SHALL have parameter TS_WIDTH, default 6: timestamp width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: event FIFO entries; power of two, at least 2.
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port spike_in  input  2  neuron spike levels; bit0 = neuron1 (address 0), bit1 = neuron2 (address 1).
REQ-006 SHALL have port aer_req  output  1  4-phase request; registered.
REQ-007 SHALL have port aer_ack  input  1  4-phase acknowledge from the receiver.
REQ-008 SHALL have port aer_addr  output  1  source address of the presented event; registered.
REQ-009 SHALL have port aer_ts  output  TS_WIDTH  timestamp of the presented event; registered.
REQ-010 SHALL have port fifo_level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-011 SHALL have port overflow  output  1  sticky flag: an event was dropped.

Function
REQ-012 SHALL register spike_in every cycle; an event on bit i is spike_in[i]==1 with the registered previous value 0.
REQ-013 SHALL run a free-running TS_WIDTH counter: +1 per cycle, wrapping from 2^TS_WIDTH-1 to 0.
REQ-014 SHALL tag each event with the counter value in the cycle the edge is detected.
REQ-015 SHALL write a single event into the FIFO at the detecting clock edge.
REQ-016 SHALL, on simultaneous events on both bits: write address 0 at that edge; hold address 1 with the same timestamp in a one-entry pending register; write it at the next edge.
REQ-017 A pending write SHALL never conflict with a new edge, because an edge on either bit needs at least 2 cycles between occurrences.
REQ-018 SHALL accept a write when fifo_level < FIFO_DEPTH, or when a pop occurs in the same cycle.
REQ-019 SHALL otherwise drop the event (including a pending one) and set overflow, which stays set until rst.
REQ-020 SHALL implement the handshake FSM states IDLE, REQ, ACKLOW; reset state IDLE.
REQ-021 IDLE: if the FIFO is non-empty at the edge, SHALL load the head into aer_addr/aer_ts, set aer_req=1 and go to REQ.
REQ-022 IDLE: aer_ack SHALL be ignored.
REQ-023 REQ: when aer_ack is sampled 1, SHALL pop the head, set aer_req=0 and go to ACKLOW; aer_addr/aer_ts SHALL stay stable while aer_req=1.
REQ-024 ACKLOW: when aer_ack is sampled 0, SHALL go to IDLE; the next event may raise aer_req at the edge after that.
REQ-025 Latency: an event detected at edge k with an empty FIFO and FSM in IDLE SHALL produce aer_req=1 after edge k+1.
REQ-026 Events SHALL be delivered in FIFO order; fifo_level SHALL equal writes minus pops, with a simultaneous write and pop leaving it unchanged.

Reset
REQ-027 rst sampled high SHALL clear aer_req, aer_addr, aer_ts, fifo_level, overflow, the timestamp counter, the pending register, and the previous-spike register; the FSM SHALL go to IDLE.
REQ-028 rst mid-handshake SHALL abort the transfer: the FIFO is flushed and aer_req drops at that edge regardless of aer_ack.
REQ-029 A spike_in level held high through reset release SHALL NOT generate an event until it falls and rises again.

Configuration
REQ-030 Macro AER_TX_TIMESTAMP_EN defined: the counter and the per-entry timestamp storage SHALL exist, and aer_ts SHALL carry timestamps per REQ-013/014.
REQ-031 AER_TX_TIMESTAMP_EN undefined: the counter and timestamp storage SHALL be omitted, and aer_ts SHALL be constant 0; all other behaviour is identical.

Verification
REQ-032 rst 1 cycle, ack tied to req delayed 1 cycle, spike_in[0] rises when counter=5 -> aer_req high after the next edge, addr=0, ts=5, one full 4-phase cycle, fifo_level back to 0.
REQ-033 spike_in 00->11 when counter=9 -> two transfers in order: (addr0, ts9) then (addr1, ts9).
REQ-034 aer_ack held 0 and 6 alternating events (DEPTH=4) -> fifo_level saturates at 4, events 5 and 6 dropped, overflow=1 until rst.
REQ-035 FIFO full, pop coinciding with a new event -> event accepted, fifo_level stays 4, overflow stays 0.
REQ-036 rst asserted while in REQ with 3 queued events -> aer_req=0 and fifo_level=0 after that edge; a spike_in still high produces no event until it toggles.
REQ-037 Counter wrap: event at counter=63 followed by an event 2 cycles later -> timestamps 63 then 1; with AER_TX_TIMESTAMP_EN undefined -> both timestamps 0.
